// File: rtl/seu_arb_pkg.sv
// Shared widths, field positions and record layout for the SEU record arbiter.
package seu_arb_pkg;

    localparam int unsigned REC_W      = 128;
    localparam int unsigned FLAG_BIT   = 127;
    localparam int unsigned CH_MSB     = 126;
    localparam int unsigned CH_LSB     = 124;
    localparam int unsigned DROP_W_DEF = 16;

    typedef struct packed {
        logic                     flag;
        logic [CH_MSB-CH_LSB:0]   ch;
        logic [CH_LSB-1:0]        payload;
    } seu_rec_t;

endpackage

// File: rtl/seu_record_arbiter_if.sv
// Readout stream (valid/ready) carrying one error record per transfer.
interface seu_record_arbiter_if;
    import seu_arb_pkg::*;

    seu_rec_t out_data;
    logic     out_valid;
    logic     out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/seu_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping modulo NUM_CH.
module seu_rr_picker #(
    parameter int unsigned NUM_CH = 7,
    parameter int unsigned IDX_W  = 3
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [NUM_CH-1:0] gnt_c,
    output logic [IDX_W-1:0]  idx_c,
    output logic              any_c
);

    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            int unsigned cand;
            cand = (32'(last_grant) + off) % NUM_CH;
            if (!any_c && req[cand]) begin
                any_c       = 1'b1;
                idx_c       = IDX_W'(cand);
                gnt_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seu_record_arbiter.sv
// Captures flagged checker records into per-channel slots and drains them round-robin
// to one readout stream. Drop counters are built only when SEU_ARB_DROP_CNT_EN is defined.
module seu_record_arbiter
    import seu_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 7,
    parameter int unsigned DROP_W = DROP_W_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH*REC_W-1:0]    rec_in,
    input  logic                       enable,
    seu_record_arbiter_if.master       out_if,
    output logic [NUM_CH-1:0]          pending,
    input  logic                       clear_drops,
    output logic [NUM_CH*DROP_W-1:0]   drop_count
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    seu_rec_t            slot_q [NUM_CH];
    logic [IDX_W-1:0]    last_grant_q;
    logic [NUM_CH-1:0]   flag_c;
    logic [NUM_CH-1:0]   pick_gnt_c;
    logic [NUM_CH-1:0]   grant_c;
    logic [NUM_CH-1:0]   capture_c;
    logic [NUM_CH-1:0]   drop_c;
    logic [IDX_W-1:0]    pick_idx_c;
    logic                pick_any_c;
    logic                loadable_c;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_flag
        assign flag_c[c] = rec_in[c*REC_W + FLAG_BIT];
    end

    seu_rr_picker #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_picker (
        .req        (pending),
        .last_grant (last_grant_q),
        .gnt_c      (pick_gnt_c),
        .idx_c      (pick_idx_c),
        .any_c      (pick_any_c)
    );

    // A slot being granted this cycle is free for a new capture on the same edge.
    always_comb begin
        loadable_c = !out_if.out_valid || out_if.out_ready;
        grant_c    = (loadable_c && pick_any_c) ? pick_gnt_c : '0;
        capture_c  = {NUM_CH{enable}} & flag_c & (~pending | grant_c);
        drop_c     = flag_c & pending & ~grant_c;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) slot_q[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (capture_c[c]) begin
                    slot_q[c]  <= seu_rec_t'(rec_in[c*REC_W +: REC_W]);
                    pending[c] <= 1'b1;
                end else if (grant_c[c]) begin
                    pending[c] <= 1'b0;
                end
            end
        end
    end

    // Output register and round-robin pointer; both hold while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= '0;
            last_grant_q     <= IDX_W'(NUM_CH - 1);
        end else if (loadable_c) begin
            if (pick_any_c) begin
                out_if.out_data  <= slot_q[pick_idx_c];
                out_if.out_valid <= 1'b1;
                last_grant_q     <= pick_idx_c;
            end else begin
                out_if.out_valid <= 1'b0;
            end
        end
    end

`ifdef SEU_ARB_DROP_CNT_EN
    logic [DROP_W-1:0] drop_q [NUM_CH];

    // Clear has priority over a coincident drop; counters saturate at all-ones.
    always_ff @(posedge clock) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (reset || clear_drops) begin
                drop_q[c] <= '0;
            end else if (drop_c[c] && (drop_q[c] != '1)) begin
                drop_q[c] <= drop_q[c] + 1'b1;
            end
        end
    end

    always_comb begin
        drop_count = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            drop_count[c*DROP_W +: DROP_W] = drop_q[c];
        end
    end
`else
    logic unused_drop;
    assign unused_drop = clear_drops ^ (^drop_c);
    assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_seu_record_arbiter.sv
// Bench for seu_record_arbiter: directed table, corner sequences and randomized traffic vs a reference model.
module tb_seu_record_arbiter;
    import seu_arb_pkg::*;

    localparam int unsigned NCH = 7;
    localparam int unsigned DW  = 4;
`ifdef SEU_ARB_DROP_CNT_EN
    localparam bit DROP_ON = 1'b1;
`else
    localparam bit DROP_ON = 1'b0;
`endif

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NCH*REC_W-1:0]   rec_in;
    logic                   enable;
    logic                   clear_drops;
    logic [NCH-1:0]         pending;
    logic [NCH*DW-1:0]      drop_count;

    seu_record_arbiter_if bus();

    seu_record_arbiter #(.NUM_CH(NCH), .DROP_W(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .rec_in      (rec_in),
        .enable      (enable),
        .out_if      (bus),
        .pending     (pending),
        .clear_drops (clear_drops),
        .drop_count  (drop_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit           m_pend [NCH];
    logic [127:0] m_slot [NCH];
    bit           m_ov;
    logic [127:0] m_od;
    int           m_last;
    int           m_drop [NCH];

    function automatic logic [127:0] mk_rec(input int ch, input int tag);
        logic [127:0] r;
        r            = '0;
        r[127]       = 1'b1;
        r[126:124]   = 3'(ch);
        r[123:116]   = ~8'(tag);
        r[63:32]     = 32'(tag * 32'h9e37_79b9);
        r[7:0]       = 8'(tag);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applies the arbiter rules to the inputs present at the clock edge.
    function automatic void model_update();
        int g;
        bit loadable;
        bit cap [NCH];
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_pend[c] = 1'b0; m_slot[c] = '0; m_drop[c] = 0;
            end
            m_ov = 1'b0; m_od = '0; m_last = NCH - 1;
            return;
        end
        loadable = !m_ov || bus.out_ready;
        g = -1;
        if (loadable) begin
            for (int k = 1; k <= NCH; k++) begin
                int c = (m_last + k) % NCH;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            bit flag = rec_in[c*REC_W + 127];
            if (DROP_ON && flag && m_pend[c] && c != g && m_drop[c] < (1 << DW) - 1) m_drop[c]++;
            if (DROP_ON && clear_drops) m_drop[c] = 0;
            cap[c] = enable && flag && (!m_pend[c] || c == g);
        end
        if (loadable) begin
            if (g >= 0) begin
                m_od = m_slot[g]; m_ov = 1'b1; m_last = g;
            end else begin
                m_ov = 1'b0;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (cap[c]) begin
                m_slot[c] = rec_in[c*REC_W +: REC_W];
                m_pend[c] = 1'b1;
            end else if (c == g) begin
                m_pend[c] = 1'b0;
            end
        end
    endfunction

    task automatic check_model();
        logic [NCH-1:0]    ep;
        logic [NCH*DW-1:0] ed;
        for (int c = 0; c < NCH; c++) begin
            ep[c] = m_pend[c];
            ed[c*DW +: DW] = DW'(m_drop[c]);
        end
        chk("model_valid", 128'(bus.out_valid), 128'(m_ov));
        chk("model_data", 128'(bus.out_data), m_od);
        chk("model_pending", 128'(pending), 128'(ep));
        chk("model_drops", 128'(drop_count), 128'(ed));
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        check_model();
    endtask

    task automatic set_flags(input logic [NCH-1:0] mask, input int tag);
        rec_in = '0;
        for (int c = 0; c < NCH; c++)
            if (mask[c]) rec_in[c*REC_W +: REC_W] = mk_rec(c, tag);
    endtask

    task automatic do_reset();
        reset = 1'b1; rec_in = '0; clear_drops = 1'b0;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        bit           rst;
        bit           rdy;
        logic [6:0]   flg;
        bit           exp_v;
        int           exp_ch;
        int           exp_tag;
        logic [6:0]   exp_pend;
        logic [3:0]   exp_drop1;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Single record on ch2, then backpressure with three records on ch1.
        tbl[0] = '{1'b1, 1'b1, 7'h00, 1'b0, 0, 0, 7'h00, 4'd0};
        tbl[1] = '{1'b0, 1'b1, 7'h04, 1'b0, 0, 0, 7'h04, 4'd0};
        tbl[2] = '{1'b0, 1'b1, 7'h00, 1'b1, 2, 1, 7'h00, 4'd0};
        tbl[3] = '{1'b0, 1'b1, 7'h00, 1'b0, 0, 0, 7'h00, 4'd0};
        tbl[4] = '{1'b0, 1'b0, 7'h02, 1'b0, 0, 0, 7'h02, 4'd0};
        tbl[5] = '{1'b0, 1'b0, 7'h02, 1'b1, 1, 4, 7'h02, 4'd0};
        tbl[6] = '{1'b0, 1'b0, 7'h02, 1'b1, 1, 4, 7'h02, 4'd1};
        tbl[7] = '{1'b0, 1'b0, 7'h00, 1'b1, 1, 4, 7'h02, 4'd1};
        tbl[8] = '{1'b0, 1'b1, 7'h00, 1'b1, 1, 5, 7'h00, 4'd1};
        tbl[9] = '{1'b0, 1'b1, 7'h00, 1'b0, 0, 0, 7'h00, 4'd1};

        reset = 1'b1; enable = 1'b1; clear_drops = 1'b0; rec_in = '0; bus.out_ready = 1'b1;
        step();
        step();

        for (int i = 0; i < 10; i++) begin
            reset = tbl[i].rst;
            bus.out_ready = tbl[i].rdy;
            set_flags(tbl[i].flg, i);
            step();
            chk("tbl_valid", 128'(bus.out_valid), 128'(tbl[i].exp_v));
            chk("tbl_pending", 128'(pending), 128'(tbl[i].exp_pend));
            chk("tbl_drop1", 128'(drop_count[1*DW +: DW]), DROP_ON ? 128'(tbl[i].exp_drop1) : 128'(0));
            if (tbl[i].exp_v) chk("tbl_data", 128'(bus.out_data), mk_rec(tbl[i].exp_ch, tbl[i].exp_tag));
            else if (tbl[i].rst) chk("tbl_reset_data", 128'(bus.out_data), 128'(0));
        end
        reset = 1'b0;

        // Round-robin: all channels at once drain in order 0..6 with no drops.
        do_reset();
        bus.out_ready = 1'b1;
        set_flags(7'h7f, 40);
        step();
        rec_in = '0;
        for (int k = 0; k < NCH; k++) begin
            step();
            chk("rr_valid", 128'(bus.out_valid), 128'(1));
            chk("rr_order", 128'(bus.out_data), mk_rec(k, 40));
        end
        chk("rr_no_drops", 128'(drop_count), 128'(0));

        // Back-to-back records on one channel with ready high: no drops.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_flags(7'h08, 60 + i);
            step();
        end
        chk("b2b_no_drops", 128'(drop_count), 128'(0));
        rec_in = '0;

        // Saturation and clear on channel 0.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 22; i++) begin
            set_flags(7'h01, i);
            step();
        end
        chk("sat_drop0", 128'(drop_count[DW-1:0]), DROP_ON ? 128'(15) : 128'(0));
        chk("sat_stall_data", 128'(bus.out_data), mk_rec(0, 0));
        set_flags(7'h01, 99);
        clear_drops = 1'b1;
        step();
        clear_drops = 1'b0;
        chk("clear_with_drop", 128'(drop_count), 128'(0));
        rec_in = '0;

        // Unflagged records never enter.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int w = 0; w < NCH*4; w++) rec_in[w*32 +: 32] = $urandom;
            for (int c = 0; c < NCH; c++) rec_in[c*REC_W + 127] = 1'b0;
            step();
        end
        chk("filter_valid", 128'(bus.out_valid), 128'(0));
        chk("filter_pending", 128'(pending), 128'(0));

        // Enable low blocks capture while held slots drain.
        bus.out_ready = 1'b0;
        set_flags(7'h50, 70);
        step();
        enable = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_flags(7'h7f, 80 + i);
            step();
        end
        chk("enable_drained", 128'(pending), 128'(0));
        chk("enable_valid", 128'(bus.out_valid), 128'(0));
        enable = 1'b1;
        rec_in = '0;

        // Reset while records are held and the output is valid.
        do_reset();
        bus.out_ready = 1'b0;
        set_flags(7'h28, 90);
        step();
        rec_in = '0;
        step();
        chk("pre_rst_valid", 128'(bus.out_valid), 128'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_data", 128'(bus.out_data), 128'(0));
        chk("rst_pending", 128'(pending), 128'(0));
        chk("rst_drops", 128'(drop_count), 128'(0));
        bus.out_ready = 1'b1;
        set_flags(7'h7f, 95);
        step();
        rec_in = '0;
        step();
        chk("rst_first_grant", 128'(bus.out_data), mk_rec(0, 95));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 299) == 0);
            clear_drops   = ($urandom_range(0, 49) == 0);
            enable        = ($urandom_range(0, 9) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            for (int w = 0; w < NCH*4; w++) rec_in[w*32 +: 32] = $urandom;
            for (int c = 0; c < NCH; c++) rec_in[c*REC_W + 127] = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
